// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register countdown scoreboard producing ID-stage
// stalls for RAW, MUL/DIV structural and WAW hazards.
module hazard_scoreboard #(
  parameter int NUM_REGS   = 32,
  parameter int AW         = 5,
  parameter int LOAD_LAT   = 1,
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 3,
  parameter int PERF_W     = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                id_valid,
  input  logic                id_flush,
  input  logic                id_is_branch,
  input  logic [AW-1:0]       id_rs1,
  input  logic [AW-1:0]       id_rs2,
  input  logic                id_rs1_used,
  input  logic                id_rs2_used,
  input  logic                id_reg_write,
  input  logic [AW-1:0]       id_rd,
  input  logic [1:0]          id_class,
  input  logic                clr_stats,
  output logic                stall,
  output logic [1:0]          stall_reason,
  output logic                muldiv_busy,
  output logic [NUM_REGS-1:0] pending_mask,
  output logic [PERF_W-1:0]   stall_cycles
);

  typedef enum logic [1:0] {CLS_ALU, CLS_LOAD, CLS_MULDIV, CLS_RSVD} cls_e;
  typedef enum logic [1:0] {RSN_NONE, RSN_RAW, RSN_STRUCT, RSN_WAW} reason_e;

  logic [CNT_W-1:0] cnt_q [NUM_REGS];
  logic [CNT_W-1:0] busy_cnt;

  logic [CNT_W-1:0] cnt_rs1, cnt_rs2, cnt_rd;
  logic [CNT_W:0]   rd_lat1;
  logic             raw, struct_h, waw, live, issue;
  reason_e          reason;
  cls_e             id_cls;

  // Producer latency plus one: cycles until the result is forwardable to EX.
  function automatic logic [CNT_W:0] lat_plus1(input cls_e c);
    case (c)
      CLS_LOAD:   return (CNT_W+1)'(LOAD_LAT + 1);
      CLS_MULDIV: return (CNT_W+1)'(MULDIV_LAT + 1);
      default:    return (CNT_W+1)'(1);
    endcase
  endfunction

  // Hazard detection from registered counters and current ID fields.
  always_comb begin
    id_cls  = cls_e'(id_class);
    cnt_rs1 = cnt_q[id_rs1];
    cnt_rs2 = cnt_q[id_rs2];
    cnt_rd  = cnt_q[id_rd];
    rd_lat1 = lat_plus1(id_cls);
    raw = 1'b0;
    if (id_rs1_used && id_rs1 != '0)
      raw = raw | (id_is_branch ? (cnt_rs1 != '0) : (cnt_rs1 > CNT_W'(1)));
    if (id_rs2_used && id_rs2 != '0)
      raw = raw | (id_is_branch ? (cnt_rs2 != '0) : (cnt_rs2 > CNT_W'(1)));
    struct_h = (id_cls == CLS_MULDIV) && (busy_cnt != '0);
    waw      = id_reg_write && (id_rd != '0) && ({1'b0, cnt_rd} > rd_lat1);
    live     = id_valid && !id_flush;
    stall    = live && (raw || struct_h || waw);
    issue    = live && !stall;
    if (!stall)        reason = RSN_NONE;
    else if (raw)      reason = RSN_RAW;
    else if (struct_h) reason = RSN_STRUCT;
    else               reason = RSN_WAW;
    stall_reason = reason;
    muldiv_busy  = busy_cnt != '0;
  end

  // Pending view of the scoreboard.
  always_comb begin
    pending_mask = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++)
      pending_mask[r] = cnt_q[r] != '0;
  end

  // Countdown timers; an issuing write reloads its entry over the decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      busy_cnt <= '0;
    end else begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (r == 0)
          cnt_q[r] <= '0;
        else if (issue && id_reg_write && id_rd == AW'(r))
          cnt_q[r] <= rd_lat1[CNT_W-1:0];
        else if (cnt_q[r] != '0)
          cnt_q[r] <= cnt_q[r] - 1'b1;
      end
      if (issue && id_cls == CLS_MULDIV)
        busy_cnt <= CNT_W'(MULDIV_LAT);
      else if (busy_cnt != '0)
        busy_cnt <= busy_cnt - 1'b1;
    end
  end

  // Saturating stall-cycle counter; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (clr_stats)
      stall_cycles <= '0;
    else if (stall && stall_cycles != '1)
      stall_cycles <= stall_cycles + 1'b1;
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed scoreboard bench for hazard_scoreboard: the driver pushes the
// hand-computed response for each cycle, the monitor pops and compares.
module tb_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        id_valid = 1'b0, id_flush = 1'b0, id_is_branch = 1'b0;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, id_rd = '0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0, id_reg_write = 1'b0;
  logic [1:0]  id_class = '0;
  logic        clr_stats = 1'b0;
  logic        stall, muldiv_busy;
  logic [1:0]  stall_reason;
  logic [31:0] pending_mask, stall_cycles;

  hazard_scoreboard #(.NUM_REGS(32), .AW(5), .LOAD_LAT(1), .MULDIV_LAT(4),
                      .CNT_W(3), .PERF_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_flush(id_flush),
    .id_is_branch(id_is_branch), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_reg_write(id_reg_write), .id_rd(id_rd), .id_class(id_class),
    .clr_stats(clr_stats), .stall(stall), .stall_reason(stall_reason),
    .muldiv_busy(muldiv_busy), .pending_mask(pending_mask),
    .stall_cycles(stall_cycles));

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        st;
    logic [1:0]  rsn;
    logic        bsy;
    logic [31:0] msk;
    logic [31:0] sc;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic logic [31:0] M(input int n);
    return 32'(1) << n;
  endfunction

  // Drive one cycle of inputs just after the rising edge and queue the response.
  task automatic vec(input string name, input logic v, fl, br,
                     input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2,
                     input logic rw, input logic [4:0] rd, input logic [1:0] cls,
                     input logic clr, rstn,
                     input logic st, input logic [1:0] rsn, input logic bsy,
                     input logic [31:0] msk, input logic [31:0] sc);
    exp_t e;
    @(posedge clk);
    #1;
    id_valid = v; id_flush = fl; id_is_branch = br;
    id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
    id_reg_write = rw; id_rd = rd; id_class = cls;
    clr_stats = clr; rst_n = rstn;
    e.name = name; e.st = st; e.rsn = rsn; e.bsy = bsy; e.msk = msk; e.sc = sc;
    q.push_back(e);
  endtask

  // Monitor: compare on the falling edge, away from the state update.
  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      n_vec++;
      if (stall !== e.st || stall_reason !== e.rsn || muldiv_busy !== e.bsy ||
          pending_mask !== e.msk || stall_cycles !== e.sc) begin
        n_bad++;
        $display("FAIL %s: got stall=%0b reason=%0d busy=%0b mask=%h cycles=%0d, expected stall=%0b reason=%0d busy=%0b mask=%h cycles=%0d",
                 e.name, stall, stall_reason, muldiv_busy, pending_mask, stall_cycles,
                 e.st, e.rsn, e.bsy, e.msk, e.sc);
      end
    end
  end

  initial begin
    //   name            v fl br rs1 u1 rs2 u2 rw rd cls clr rn | st rsn bsy mask    cyc
    vec("reset",         0,0,0,  0,0, 0,0, 0, 0,0, 0,0,  0,0,0, 0,     0);
    vec("post_reset",    0,0,0,  0,0, 0,0, 0, 0,0, 0,1,  0,0,0, 0,     0);
    // ALU producer, ALU and branch consumers
    vec("alu_x5",        1,0,0,  0,0, 0,0, 1, 5,0, 0,1,  0,0,0, 0,     0);
    vec("alu_use_x5",    1,0,0,  5,1, 0,0, 0, 0,0, 0,1,  0,0,0, M(5),  0);
    vec("alu_x5_b",      1,0,0,  0,0, 0,0, 1, 5,0, 0,1,  0,0,0, 0,     0);
    vec("br_x5_stall",   1,0,1,  5,1, 0,0, 0, 0,0, 0,1,  1,1,0, M(5),  0);
    vec("br_x5_go",      1,0,1,  5,1, 0,0, 0, 0,0, 0,1,  0,0,0, 0,     1);
    // LOAD producer, branch then ALU consumer
    vec("ld_x6",         1,0,0,  0,0, 0,0, 1, 6,1, 0,1,  0,0,0, 0,     1);
    vec("br_x6_s1",      1,0,1,  6,1, 0,1, 0, 0,0, 0,1,  1,1,0, M(6),  1);
    vec("br_x6_s2",      1,0,1,  6,1, 0,1, 0, 0,0, 0,1,  1,1,0, M(6),  2);
    vec("br_x6_go",      1,0,1,  6,1, 0,1, 0, 0,0, 0,1,  0,0,0, 0,     3);
    vec("ld_x6_b",       1,0,0,  0,0, 0,0, 1, 6,1, 0,1,  0,0,0, 0,     3);
    vec("add_x6_s1",     1,0,0,  6,1, 0,0, 0, 0,0, 0,1,  1,1,0, M(6),  3);
    vec("add_x6_go",     1,0,0,  6,1, 0,0, 0, 0,0, 0,1,  0,0,0, M(6),  4);
    // MULDIV producer, RAW consumer add x8,x7,x1
    vec("mul_x7",        1,0,0,  0,0, 0,0, 1, 7,2, 0,1,  0,0,0, 0,     4);
    vec("add_x7_s1",     1,0,0,  7,1, 1,1, 1, 8,0, 0,1,  1,1,1, M(7),  4);
    vec("add_x7_s2",     1,0,0,  7,1, 1,1, 1, 8,0, 0,1,  1,1,1, M(7),  5);
    vec("add_x7_s3",     1,0,0,  7,1, 1,1, 1, 8,0, 0,1,  1,1,1, M(7),  6);
    vec("add_x7_s4",     1,0,0,  7,1, 1,1, 1, 8,0, 0,1,  1,1,1, M(7),  7);
    vec("add_x7_go",     1,0,0,  7,1, 1,1, 1, 8,0, 0,1,  0,0,0, M(7),  8);
    vec("idle_x8",       0,0,0,  0,0, 0,0, 0, 0,0, 0,1,  0,0,0, M(8),  8);
    // MULDIV structural conflict
    vec("mul_x9",        1,0,0,  0,0, 0,0, 1, 9,2, 0,1,  0,0,0, 0,     8);
    vec("mul_x10_s1",    1,0,0,  0,0, 0,0, 1,10,2, 0,1,  1,2,1, M(9),  8);
    vec("mul_x10_s2",    1,0,0,  0,0, 0,0, 1,10,2, 0,1,  1,2,1, M(9),  9);
    vec("mul_x10_s3",    1,0,0,  0,0, 0,0, 1,10,2, 0,1,  1,2,1, M(9), 10);
    vec("mul_x10_s4",    1,0,0,  0,0, 0,0, 1,10,2, 0,1,  1,2,1, M(9), 11);
    vec("mul_x10_go",    1,0,0,  0,0, 0,0, 1,10,2, 0,1,  0,0,0, M(9), 12);
    vec("drain1",        0,0,0,  0,0, 0,0, 0, 0,0, 0,1,  0,0,1, M(10),12);
    vec("drain2",        0,0,0,  0,0, 0,0, 0, 0,0, 0,1,  0,0,1, M(10),12);
    vec("drain3",        0,0,0,  0,0, 0,0, 0, 0,0, 0,1,  0,0,1, M(10),12);
    vec("drain4",        0,0,0,  0,0, 0,0, 0, 0,0, 0,1,  0,0,1, M(10),12);
    vec("drain5",        0,0,0,  0,0, 0,0, 0, 0,0, 0,1,  0,0,0, M(10),12);
    // WAW: ALU write to x11 behind a MULDIV write; clear wins over increment
    vec("mul_x11",       1,0,0,  0,0, 0,0, 1,11,2, 0,1,  0,0,0, 0,    12);
    vec("waw_x11_s1",    1,0,0,  0,0, 0,0, 1,11,0, 0,1,  1,3,1, M(11),12);
    vec("waw_x11_s2",    1,0,0,  0,0, 0,0, 1,11,0, 0,1,  1,3,1, M(11),13);
    vec("waw_x11_s3",    1,0,0,  0,0, 0,0, 1,11,0, 0,1,  1,3,1, M(11),14);
    vec("waw_x11_s4_clr",1,0,0,  0,0, 0,0, 1,11,0, 1,1,  1,3,1, M(11),15);
    vec("waw_x11_go",    1,0,0,  0,0, 0,0, 1,11,0, 0,1,  0,0,0, M(11), 0);
    // x0 reads and writes never create hazards
    vec("x0_branch_ld",  1,0,1,  0,1, 0,1, 1, 0,1, 0,1,  0,0,0, M(11), 0);
    vec("x0_not_pend",   0,0,0,  0,0, 0,0, 0, 0,0, 0,1,  0,0,0, 0,     0);
    // Flush suppresses stall and issue
    vec("mul_x13",       1,0,0,  0,0, 0,0, 1,13,2, 0,1,  0,0,0, 0,     0);
    vec("flush_x13",     1,1,0, 13,1, 0,0, 1,14,1, 0,1,  0,0,1, M(13), 0);
    vec("flush_noload",  0,0,0,  0,0, 0,0, 0, 0,0, 0,1,  0,0,1, M(13), 0);
    // Asynchronous reset mid-countdown with a dependent consumer in ID
    vec("reset_mid",     1,0,0, 13,1, 0,0, 0, 0,0, 0,0,  0,0,0, 0,     0);
    vec("reset_release", 1,0,0, 13,1, 0,0, 0, 0,0, 0,1,  0,0,0, 0,     0);

    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_timeout: got %0d responses pending, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
